// File: rtl/bounded_scan_arbiter.sv
// Round-robin arbiter sharing one bounded index-scan datapath (x counter, m capture) among NREQ
// requesters. Define BOUNDED_SCAN_ASSERT_EN to compile the embedded invariant assertions.
module bounded_scan_arbiter #(
  parameter int unsigned W    = 16,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_bound,
  input  logic              sel,
  input  logic              abort,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [W-1:0]      x_out,
  output logic [W-1:0]      n_out,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [W-1:0]      result_m,
  output logic              result_hit,
  output logic              result_abort
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d, m_q, m_d, n_q, n_d;
  logic            hit_q, hit_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d, rr_q, rr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [W-1:0]    result_m_q, result_m_d;
  logic            result_hit_q, result_hit_d;
  logic            result_abort_q, result_abort_d;

  logic [W-1:0]    bound_arr [NREQ];
  logic            found;
  logic [IDW-1:0]  pick_id, idx;
  int unsigned     idx_int;

  for (genvar g = 0; g < NREQ; g++) begin : g_bound
    assign bound_arr[g] = req_bound[g*W +: W];
  end

  // First requesting index at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    idx     = '0;
    idx_int = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_int = (int'(rr_q) + k) % NREQ;
      idx     = IDW'(idx_int);
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    m_d            = m_q;
    n_d            = n_q;
    hit_d          = hit_q;
    cur_id_d       = cur_id_q;
    rr_d           = rr_q;
    grant_d        = '0;
    done_d         = 1'b0;
    done_id_d      = done_id_q;
    result_m_d     = result_m_q;
    result_hit_d   = result_hit_q;
    result_abort_d = result_abort_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          n_d              = bound_arr[pick_id];
          x_d              = '0;
          m_d              = '0;
          hit_d            = 1'b0;
          cur_id_d         = pick_id;
          rr_d             = IDW'((int'(pick_id) + 1) % NREQ);
          grant_d[pick_id] = 1'b1;
          result_m_d       = '0;
          result_hit_d     = 1'b0;
          result_abort_d   = 1'b0;
          state_d          = StRun;
        end
      end
      StRun: begin
        if (x_q < n_q) begin
          if (sel) begin
            m_d   = x_q;
            hit_d = 1'b1;
          end
          // abort freezes x but still honours a same-cycle capture
          if (!abort) x_d = x_q + W'(1);
        end
        if (abort || (x_q >= n_q)) begin
          state_d        = StDone;
          done_d         = 1'b1;
          done_id_d      = cur_id_q;
          result_m_d     = m_d;
          result_hit_d   = hit_d;
          result_abort_d = abort;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      x_q            <= '0;
      m_q            <= '0;
      n_q            <= '0;
      hit_q          <= 1'b0;
      cur_id_q       <= '0;
      rr_q           <= '0;
      grant_q        <= '0;
      done_q         <= 1'b0;
      done_id_q      <= '0;
      result_m_q     <= '0;
      result_hit_q   <= 1'b0;
      result_abort_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      m_q            <= m_d;
      n_q            <= n_d;
      hit_q          <= hit_d;
      cur_id_q       <= cur_id_d;
      rr_q           <= rr_d;
      grant_q        <= grant_d;
      done_q         <= done_d;
      done_id_q      <= done_id_d;
      result_m_q     <= result_m_d;
      result_hit_q   <= result_hit_d;
      result_abort_q <= result_abort_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q != StIdle);
  assign x_out        = x_q;
  assign n_out        = n_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign result_m     = result_m_q;
  assign result_hit   = result_hit_q;
  assign result_abort = result_abort_q;

`ifdef BOUNDED_SCAN_ASSERT_EN
  a_x_le_n: assert property (@(posedge clk) disable iff (rst) x_q <= n_q);
  a_m_lt_n: assert property (@(posedge clk) disable iff (rst)
                             !((x_q >= n_q) && (n_q > 0) && hit_q && (m_q >= n_q)));
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_done_no_grant: assert property (@(posedge clk) disable iff (rst) !(done_q && (|grant_q)));
  a_done_after_run: assert property (@(posedge clk) disable iff (rst)
                                     done_q |-> ($past(state_q) == StRun));
  for (genvar g = 0; g < NREQ; g++) begin : g_grant_req
    a_grant_req: assert property (@(posedge clk) disable iff (rst) grant_q[g] |-> $past(req[g]));
  end
`endif

endmodule

// File: doc/bounded_scan_arbiter.md
Name: bounded_scan_arbiter

Overview:
- Shares one bounded index-scan datapath between NREQ requesters.
- The datapath has a scan counter x stepping 0..n-1 and a capture register m that records x when the sample strobe sel is high.
- Round-robin arbitration selects one requester, the block loads its bound, runs the scan to completion, then returns the captured index with a done pulse.
- Sits between requesting agents and the shared scan resource; owns all sequencing of x, m and n.

Parameters:
- W, 16, width of bound, counter and capture registers.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID (clog2(NREQ)).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester scan request, level; held until granted
- req_bound  input  NREQ*W  per-requester bound n; slice i = bits [i*W +: W]
- sel  input  1  sample strobe; when high in a RUN step, m captures current x
- abort  input  1  terminates an active scan early
- grant  output  NREQ  one-hot; high exactly one cycle, in the first RUN cycle
- busy  output  1  high in RUN and DONE
- x_out  output  W  current scan index
- n_out  output  W  latched bound
- done  output  1  one-cycle pulse at scan end
- done_id  output  IDW  ID of the finished requester; valid with done
- result_m  output  W  captured index; valid with done
- result_hit  output  1  1 if sel was seen at least once during the scan
- result_abort  output  1  1 if the scan ended via abort

Behaviour:
- Reset values: all outputs 0. x=0, m=0, n=0, hit=0. RR pointer = 0, meaning requester 0 has highest priority. State = IDLE.
- FSM states: IDLE, RUN, DONE. All outputs are registered.

IDLE:
- If any req bit is set, choose the first set index at or after the RR pointer, wrapping modulo NREQ.
- On the next edge: n <= req_bound[id]; x <= 0; m <= 0; hit <= 0; cur_id <= id; RR pointer <= (id+1) mod NREQ.
- Then enter RUN with grant[id] = 1 for that first RUN cycle only.
- The requester must drop req by the cycle after grant. A req still high after that is treated as a new request.

RUN:
- Each cycle with x < n: x <= x+1, saturating; no wrap past n.
- If sel is high in that cycle: m <= x and hit <= 1. sel is ignored once x >= n.
- When x == n, or immediately if n == 0: next edge enters DONE.
- A bound of N therefore spends N+1 cycles in RUN, including the terminal x == n cycle.
- abort in RUN: next edge enters DONE with result_abort = 1. x, m and hit freeze at their current values.
- If x < n and sel are high in the same cycle as abort, the capture still happens.

DONE:
- Lasts exactly one cycle, with done = 1.
- done_id = cur_id; result_m = m; result_hit = hit; result_abort as set.
- Next edge returns to IDLE. A req present during DONE is evaluated in the following IDLE cycle.
- Results hold until the next grant; done does not hold.

Invariants:
- x <= n at all times.
- If hit = 1 and n > 0, then m < n.
- grant is one-hot or zero.
- done and grant are never high together.

Other rules:
- Arithmetic is unsigned W-bit.
- rst mid-scan: returns to IDLE next cycle with all reset values. No done pulse is issued for the killed scan.

Optional Feature:
- Macro: BOUNDED_SCAN_ASSERT_EN.
- When defined, the block includes concurrent assertions:
  - x <= n
  - !(x >= n && n > 0 && hit && m >= n)
  - $onehot0(grant)
  - !(done && grant)
  - done implies the previous state was RUN
  - requester i granted implies req[i] was high in the prior cycle
- When undefined, no assertion code is compiled and functional behaviour is identical.

Test Plan:
- Bound 5 from req[0], sel held high: grant[0] 1 cycle after req; x steps 0..5; done 7 cycles after the req edge; result_m = 4, result_hit = 1, done_id = 0.
- Bound 500 with sel never high: done after 501 RUN cycles; result_hit = 0, result_m = 0, x_out = 500.
- Bound 0: grant, then done on the next cycle; result_hit = 0.
- req = 4'b1111 held continuously with bound 3 each: grant order 0,1,2,3,0; consecutive grants separated by the RUN+DONE+IDLE cycles.
- Bound 10 with sel pulsed at x = 2 and x = 6, abort at x = 8: done with result_abort = 1, result_m = 6, x_out = 8.
- rst asserted at x = 3 of a bound-100 scan: next cycle all outputs are 0 and no done pulse. A pending req[2] is granted after rst drops.
